// File: rtl/queue_pkg.sv
// Shared definitions for the queue pop reader: default data width, stats width
// and FSM state encoding.
package queue_pkg;

   localparam int unsigned QUEUE_DATA_W = 4;
   localparam int unsigned STATS_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/queue_reader_buf.sv
// Two-entry FIFO-ordered valid/ready output buffer; m_data is always the oldest
// word and stays put while the consumer stalls.
module queue_reader_buf
   import queue_pkg::*;
#(
   parameter int unsigned DATA_W = QUEUE_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [1:0]        count,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready
);

   logic [DATA_W-1:0] slot0_q, slot0_d;
   logic [DATA_W-1:0] slot1_q, slot1_d;
   logic [1:0]        count_q, count_d;
   logic              rd;

   assign rd = (count_q != 2'd0) && m_ready;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      unique case ({wr_en, rd})
         2'b10: begin
            if (count_q == 2'd0) slot0_d = wr_data;
            else                 slot1_d = wr_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
         end
         // Simultaneous read and write: the occupancy is unchanged, the head advances.
         2'b11: begin
            if (count_q == 2'd2) begin
               slot0_d = slot1_q;
               slot1_d = wr_data;
            end else begin
               slot0_d = wr_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= '0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign m_valid = (count_q != 2'd0);
   assign m_data  = slot0_q;

endmodule

// File: rtl/queue_pop_reader.sv
// Pop master for the 4-bit shift queue: burst FSM, pop gating and 2-entry output buffer.
// Optional statistics (words_total, underrun) are enabled by defining QUEUE_READER_STATS_EN.
module queue_pop_reader
   import queue_pkg::*;
#(
   parameter int unsigned DATA_W  = QUEUE_DATA_W,
   parameter int unsigned BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   input  logic               q_empty,
   input  logic [DATA_W-1:0]  q_data,
   output logic               q_enable,
   output logic               q_push_pop,
   output logic               m_valid,
   output logic [DATA_W-1:0]  m_data,
   input  logic               m_ready
`ifdef QUEUE_READER_STATS_EN
   ,
   output logic [STATS_W-1:0] words_total,
   output logic [0:0]         underrun
`endif
);

   state_e             state_q, state_d;
   logic [BURST_W-1:0] remaining_q, remaining_d;
   logic               drain_mode_q, drain_mode_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [1:0]         buf_count;
   logic               space;
   logic               pop_fire;

   assign space    = (buf_count < 2'd2) || (m_valid && m_ready);
   assign pop_fire = (state_q == ST_RUN) && !q_empty && !abort && space &&
                     (drain_mode_q || (remaining_q != '0));

   assign q_enable   = pop_fire;
   assign q_push_pop = 1'b0;

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      drain_mode_d = drain_mode_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d      = ST_RUN;
               remaining_d  = burst_len;
               drain_mode_d = (burst_len == '0);
               busy_d       = 1'b1;
            end
         end
         ST_RUN: begin
            if (pop_fire && !drain_mode_q) remaining_d = remaining_q - BURST_W'(1);
            if (abort || (drain_mode_q && q_empty) ||
                (pop_fire && !drain_mode_q && (remaining_q == BURST_W'(1))))
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (buf_count == 2'd0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         remaining_q  <= '0;
         drain_mode_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         drain_mode_q <= drain_mode_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   // The queue's data_out is captured on the same edge that its pop takes effect.
   queue_reader_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (pop_fire),
      .wr_data (q_data),
      .count   (buf_count),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready)
   );

`ifdef QUEUE_READER_STATS_EN
   logic [STATS_W-1:0] words_q;
   logic               underrun_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         if (pop_fire && (words_q != '1)) words_q <= words_q + STATS_W'(1);
         if ((state_q == ST_RUN) && q_empty && !drain_mode_q && (remaining_q != '0))
            underrun_q <= 1'b1;
      end
   end

   assign words_total = words_q;
   assign underrun    = underrun_q;
`endif

endmodule

// File: tb/tb_queue_pop_reader.sv
// Directed bench for queue_pop_reader with a behavioural shift-queue model;
// define QUEUE_READER_STATS_EN to also cover the statistics outputs.
module tb_queue_pop_reader;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] burst_len;
   logic       abort;
   logic       busy;
   logic       done;
   logic       q_empty;
   logic [3:0] q_data;
   logic       q_enable;
   logic       q_push_pop;
   logic       m_valid;
   logic [3:0] m_data;
   logic       m_ready;
`ifdef QUEUE_READER_STATS_EN
   logic [15:0] words_total;
   logic [0:0]  underrun;
`endif

   logic [3:0] qmem [8];
   int         qcnt;
   int         n_cmp;
   int         n_fail;
   int         viol;

   assign q_empty = (qcnt == 0);
   assign q_data  = qmem[0];

   queue_pop_reader #(
      .DATA_W  (4),
      .BURST_W (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .burst_len  (burst_len),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .q_empty    (q_empty),
      .q_data     (q_data),
      .q_enable   (q_enable),
      .q_push_pop (q_push_pop),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready)
`ifdef QUEUE_READER_STATS_EN
      ,
      .words_total (words_total),
      .underrun    (underrun)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       st;
      logic [3:0] len;
      logic       ab;
      logic       rdy;
      logic       busy;
      logic       done;
      logic       qen;
      logic       mv;
      logic [3:0] md;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic st, input logic [3:0] len, input logic ab,
                               input logic rdy, input logic b, input logic d,
                               input logic qe, input logic mv, input logic [3:0] md);
      vec_t v;
      v.st = st; v.len = len; v.ab = ab; v.rdy = rdy;
      v.busy = b; v.done = d; v.qen = qe; v.mv = mv; v.md = md;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic qpush(input logic [3:0] v);
      qmem[qcnt] = v;
      qcnt++;
   endtask

   // One clock: decide the pop from q_enable before the edge, shift the model after it.
   task automatic cyc();
      logic pop;
      if (q_enable && q_empty) viol++;
      pop = q_enable && (qcnt > 0);
      @(posedge clk);
      #1;
      if (pop) begin
         for (int i = 0; i < 7; i++) qmem[i] = qmem[i + 1];
         qcnt--;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; burst_len = '0; abort = 1'b0; m_ready = 1'b0;
      qcnt = 0;
      for (int i = 0; i < 8; i++) qmem[i] = '0;
      cyc(); cyc();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic run_table(input string nm);
      for (int i = 0; i < tbl.size(); i++) begin
         start = tbl[i].st; burst_len = tbl[i].len; abort = tbl[i].ab; m_ready = tbl[i].rdy;
         #1;
         check($sformatf("%s[%0d].busy", nm, i), busy, tbl[i].busy);
         check($sformatf("%s[%0d].done", nm, i), done, tbl[i].done);
         check($sformatf("%s[%0d].q_enable", nm, i), q_enable, tbl[i].qen);
         check($sformatf("%s[%0d].m_valid", nm, i), m_valid, tbl[i].mv);
         if (tbl[i].mv) check($sformatf("%s[%0d].m_data", nm, i), m_data, tbl[i].md);
         cyc();
      end
      tbl.delete();
   endtask

   task automatic run_burst(input logic [3:0] len, input string nm);
      int seen;
      seen = 0;
      start = 1'b1; burst_len = len; m_ready = 1'b1; abort = 1'b0;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 40 && seen == 0; k++) begin
         #1;
         if (done) seen = 1;
         cyc();
      end
      check({nm, ".done_seen"}, seen, 1);
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; viol = 0;
      do_reset();
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.q_enable", q_enable, 0);
      check("reset.m_valid", m_valid, 0);
      check("reset.m_data", m_data, 0);
      check("reset.q_push_pop", q_push_pop, 0);

      // Fixed burst of 2 from a 3-word queue.
      qpush(4'd9); qpush(4'd5); qpush(4'd3);
      tbl.push_back(mk(1, 4'd2, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'd2, 0, 1, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 4'd2, 0, 1, 1, 0, 1, 1, 4'd9));
      tbl.push_back(mk(0, 4'd2, 0, 1, 1, 0, 0, 1, 4'd5));
      tbl.push_back(mk(0, 4'd2, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'd2, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4'd2, 0, 1, 0, 0, 0, 0, 0));
      run_table("burst2");
      check("burst2.q_left", qcnt, 1);
      check("burst2.q_head", qmem[0], 3);

      // Drain-until-empty with 4 words.
      do_reset();
      qpush(4'd1); qpush(4'd2); qpush(4'd3); qpush(4'd4);
      tbl.push_back(mk(1, 4'd0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 1, 1, 4'd1));
      tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 1, 1, 4'd2));
      tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 1, 1, 4'd3));
      tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 0, 1, 4'd4));
      tbl.push_back(mk(0, 4'd0, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 0, 0, 0));
      run_table("drain0");
      check("drain0.q_left", qcnt, 0);

      // Back-pressure: two pops fill the buffer, then none until m_ready returns.
      do_reset();
      qpush(4'd6); qpush(4'd7); qpush(4'd8); qpush(4'd9);
      tbl.push_back(mk(1, 4'd3, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'd3, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 4'd3, 0, 0, 1, 0, 1, 1, 4'd6));
      tbl.push_back(mk(0, 4'd3, 0, 0, 1, 0, 0, 1, 4'd6));
      tbl.push_back(mk(0, 4'd3, 0, 0, 1, 0, 0, 1, 4'd6));
      tbl.push_back(mk(0, 4'd3, 0, 0, 1, 0, 0, 1, 4'd6));
      tbl.push_back(mk(0, 4'd3, 0, 1, 1, 0, 1, 1, 4'd6));
      tbl.push_back(mk(0, 4'd3, 0, 1, 1, 0, 0, 1, 4'd7));
      tbl.push_back(mk(0, 4'd3, 0, 1, 1, 0, 0, 1, 4'd8));
      tbl.push_back(mk(0, 4'd3, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'd3, 0, 1, 0, 1, 0, 0, 0));
      run_table("stall");
      check("stall.q_left", qcnt, 1);

      // Abort with two words buffered and three still queued.
      do_reset();
      qpush(4'd1); qpush(4'd2); qpush(4'd3); qpush(4'd4); qpush(4'd5);
      tbl.push_back(mk(1, 4'd7, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'd7, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 4'd7, 0, 0, 1, 0, 1, 1, 4'd1));
      tbl.push_back(mk(0, 4'd7, 1, 0, 1, 0, 0, 1, 4'd1));
      tbl.push_back(mk(0, 4'd7, 0, 1, 1, 0, 0, 1, 4'd1));
      tbl.push_back(mk(0, 4'd7, 0, 1, 1, 0, 0, 1, 4'd2));
      tbl.push_back(mk(0, 4'd7, 0, 1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'd7, 0, 1, 0, 1, 0, 0, 0));
      run_table("abort");
      check("abort.q_left", qcnt, 3);

      // Asynchronous reset in the middle of a burst, then a fresh burst.
      do_reset();
      qpush(4'd10); qpush(4'd11); qpush(4'd12);
      start = 1'b1; burst_len = 4'd3; m_ready = 1'b0;
      cyc();
      start = 1'b0;
      cyc(); cyc();
      check("rst_mid.m_valid_before", m_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid.m_valid", m_valid, 0);
      check("rst_mid.busy", busy, 0);
      check("rst_mid.q_enable", q_enable, 0);
      cyc(); cyc();
      check("rst_mid.q_left", qcnt, 1);
      rst_n = 1'b1;
      #1;
      begin
         int got;
         int seen;
         got = -1; seen = 0;
         start = 1'b1; burst_len = 4'd1; m_ready = 1'b1;
         cyc();
         start = 1'b0;
         for (int k = 0; k < 20 && seen == 0; k++) begin
            #1;
            if (m_valid && m_ready) got = int'(m_data);
            if (done) seen = 1;
            cyc();
         end
         check("restart.word", got, 12);
         check("restart.done_seen", seen, 1);
      end

`ifdef QUEUE_READER_STATS_EN
      do_reset();
      check("stats.reset_total", words_total, 0);
      qpush(4'd1); qpush(4'd2); qpush(4'd3);
      run_burst(4'd3, "stats.b3");
      qpush(4'd4); qpush(4'd5);
      run_burst(4'd2, "stats.b2");
      check("stats.words_total", words_total, 5);
      check("stats.underrun_clear", underrun, 0);
      qpush(4'd7);
      start = 1'b1; burst_len = 4'd4; m_ready = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      check("stats.underrun_set", underrun, 1);
      check("stats.still_busy", busy, 1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      repeat (4) cyc();
      check("stats.after_abort_busy", busy, 0);
      check("stats.words_total_6", words_total, 6);
`endif

      check("q_enable_while_empty", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
